// File: rtl/mult_sched_if.sv
// mult_sched_if: request, multiplier and response signals of the multiplier scheduler.
// Ports (signals):
//   req/req_a/req_b          requester -> scheduler, per-channel request and packed operands
//   gnt                      scheduler -> requester, one-hot operand-capture pulse
//   mul_start/mul_a/mul_b    scheduler -> multiplier, launch pulse and operands
//   mul_done/mul_result      multiplier -> scheduler, product and its valid pulse
//   resp_vld/resp_id/resp_data/resp_err, resp_rdy   response valid/ready channel
// Modports: slave = scheduler side, master = environment side.
interface mult_sched_if #(
   parameter int unsigned NCH = 4,
   parameter int unsigned N   = 4,
   parameter int unsigned M   = 4
);
   localparam int unsigned IDW = $clog2(NCH);
   localparam int unsigned PW  = N + M;

   logic [NCH-1:0]   req;
   logic [NCH*N-1:0] req_a;
   logic [NCH*M-1:0] req_b;
   logic [NCH-1:0]   gnt;
   logic             mul_start;
   logic [N-1:0]     mul_a;
   logic [M-1:0]     mul_b;
   logic             mul_done;
   logic [PW-1:0]    mul_result;
   logic             resp_vld;
   logic             resp_rdy;
   logic [IDW-1:0]   resp_id;
   logic [PW-1:0]    resp_data;
   logic             resp_err;

   modport slave (
      input  req, req_a, req_b, mul_done, mul_result, resp_rdy,
      output gnt, mul_start, mul_a, mul_b, resp_vld, resp_id, resp_data, resp_err
   );

   modport master (
      output req, req_a, req_b, mul_done, mul_result, resp_rdy,
      input  gnt, mul_start, mul_a, mul_b, resp_vld, resp_id, resp_data, resp_err
   );
endinterface

// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler sharing one external multiplier among NCH requesters,
// with at most one operation outstanding.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_sched_if.slave: req/req_a/req_b in, gnt out; mul_start/mul_a/mul_b out,
//          mul_done/mul_result in; resp_vld/resp_id/resp_data/resp_err out, resp_rdy in
// Optional feature: define MULT_SCHED_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles
// without mul_done (response with resp_data=0, resp_err=1). Undefined: resp_err is tied 0.
module mult_sched #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned N       = 4,
   parameter int unsigned M       = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input logic         clk,
   input logic         rst_n,
   mult_sched_if.slave bus
);
   localparam int unsigned IDW = $clog2(NCH);
   localparam int unsigned PW  = N + M;

   // Elaboration-time parameter sanity
   if (NCH < 2 || NCH > 16) begin : g_bad_nch
      $error("mult_sched: NCH must be in 2..16");
   end
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("mult_sched: TIMEOUT must be nonzero");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [NCH-1:0] gnt_q, gnt_d;
   logic           mul_start_q, mul_start_d;
   logic [N-1:0]   mul_a_q, mul_a_d;
   logic [M-1:0]   mul_b_q, mul_b_d;
   logic           resp_vld_q, resp_vld_d;
   logic [IDW-1:0] resp_id_q, resp_id_d;
   logic [PW-1:0]  resp_data_q, resp_data_d;

   logic           found_c;
   logic [IDW-1:0] win_c;
   logic [IDW-1:0] cand_c;
   logic [N-1:0]   sel_a_c;
   logic [M-1:0]   sel_b_c;

`ifdef MULT_SCHED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic          resp_err_q, resp_err_d;
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   // Round-robin search starting one past the last granted channel
   always_comb begin
      found_c = 1'b0;
      win_c   = '0;
      cand_c  = '0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         cand_c = IDW'((32'(ptr_q) + k) % NCH);
         if (!found_c && bus.req[cand_c]) begin
            found_c = 1'b1;
            win_c   = cand_c;
         end
      end
   end

   // Operand mux for the winning channel
   always_comb begin
      sel_a_c = '0;
      sel_b_c = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (win_c == IDW'(i)) begin
            sel_a_c = bus.req_a[i*N +: N];
            sel_b_c = bus.req_b[i*M +: M];
         end
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = '0;
      mul_start_d = 1'b0;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      resp_vld_d  = resp_vld_q;
      resp_id_d   = resp_id_q;
      resp_data_d = resp_data_q;
`ifdef MULT_SCHED_TIMEOUT_EN
      resp_err_d  = resp_err_q;
      tmo_d       = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (found_c) begin
               gnt_d[win_c] = 1'b1;
               mul_start_d  = 1'b1;
               mul_a_d      = sel_a_c;
               mul_b_d      = sel_b_c;
               resp_id_d    = win_c;
               ptr_d        = win_c;
               state_d      = WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
               tmo_d        = '0;
`endif
            end
         end
         WAIT: begin
            // mul_done wins over a timeout expiring on the same cycle
            if (bus.mul_done) begin
               resp_data_d = bus.mul_result;
               resp_vld_d  = 1'b1;
               state_d     = RESP;
`ifdef MULT_SCHED_TIMEOUT_EN
               resp_err_d  = 1'b0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               resp_data_d = '0;
               resp_err_d  = 1'b1;
               resp_vld_d  = 1'b1;
               state_d     = RESP;
            end else begin
               tmo_d       = tmo_q + TW'(1);
`endif
            end
         end
         RESP: begin
            if (resp_vld_q && bus.resp_rdy) begin
               resp_vld_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; pointer resets so channel 0 is searched first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= IDW'(NCH - 1);
         gnt_q       <= '0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         resp_vld_q  <= 1'b0;
         resp_id_q   <= '0;
         resp_data_q <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
         resp_err_q  <= 1'b0;
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         resp_vld_q  <= resp_vld_d;
         resp_id_q   <= resp_id_d;
         resp_data_q <= resp_data_d;
`ifdef MULT_SCHED_TIMEOUT_EN
         resp_err_q  <= resp_err_d;
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.mul_start = mul_start_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.resp_vld  = resp_vld_q;
   assign bus.resp_id   = resp_id_q;
   assign bus.resp_data = resp_data_q;
`ifdef MULT_SCHED_TIMEOUT_EN
   assign bus.resp_err  = resp_err_q;
`else
   assign bus.resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed and randomized checks of mult_sched against a transaction-level
// model; also emulates requesters and the shared multiplier.
module tb_mult_sched;
   localparam int unsigned NCH     = 4;
   localparam int unsigned N       = 4;
   localparam int unsigned M       = 4;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned IDW     = 2;
   localparam int unsigned PW      = N + M;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mult_sched_if #(.NCH(NCH), .N(N), .M(M)) bus ();

   mult_sched #(.NCH(NCH), .N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int rr_pick(input logic [NCH-1:0] r, input int last);
      logic [NCH-1:0] s;
      int c;
      for (int k = 1; k <= int'(NCH); k++) begin
         c = (last + k) % int'(NCH);
         s = r >> c;
         if (s[0]) return c;
      end
      return -1;
   endfunction

   function automatic int idx_of(input logic [NCH-1:0] g);
      logic [NCH-1:0] s;
      for (int k = 0; k < int'(NCH); k++) begin
         s = g >> k;
         if (s[0]) return k;
      end
      return -1;
   endfunction

   logic [NCH-1:0] e_gnt;
   logic           e_start;
   logic [N-1:0]   e_a;
   logic [M-1:0]   e_b;
   logic           e_vld;
   logic [IDW-1:0] e_id;
   logic [PW-1:0]  e_data;
   logic           e_err;
   bit             m_busy;
   int             m_last;
   int             m_age;
   int             pick;

   always_comb pick = rr_pick(bus.req, m_last);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_gnt <= '0; e_start <= 1'b0; e_a <= '0; e_b <= '0;
         e_vld <= 1'b0; e_id <= '0; e_data <= '0; e_err <= 1'b0;
         m_busy <= 1'b0; m_last <= int'(NCH) - 1; m_age <= 0;
      end else begin
         e_gnt   <= '0;
         e_start <= 1'b0;
         if (m_busy) begin
            if (bus.mul_done) begin
               e_vld <= 1'b1; e_data <= bus.mul_result; e_err <= 1'b0; m_busy <= 1'b0;
            end
`ifdef MULT_SCHED_TIMEOUT_EN
            else if (m_age + 1 == int'(TIMEOUT)) begin
               e_vld <= 1'b1; e_data <= '0; e_err <= 1'b1; m_busy <= 1'b0;
            end
`endif
            else m_age <= m_age + 1;
         end else if (e_vld) begin
            if (bus.resp_rdy) e_vld <= 1'b0;
         end else if (pick >= 0) begin
            e_gnt   <= NCH'(1) << pick;
            e_start <= 1'b1;
            e_a     <= N'(bus.req_a >> (pick * int'(N)));
            e_b     <= M'(bus.req_b >> (pick * int'(M)));
            e_id    <= IDW'(pick);
            m_last  <= pick;
            m_busy  <= 1'b1;
            m_age   <= 0;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("gnt",       bus.gnt,       e_gnt);
         cmp("mul_start", bus.mul_start, e_start);
         cmp("mul_a",     bus.mul_a,     e_a);
         cmp("mul_b",     bus.mul_b,     e_b);
         cmp("resp_vld",  bus.resp_vld,  e_vld);
         cmp("resp_id",   bus.resp_id,   e_id);
         cmp("resp_data", bus.resp_data, e_data);
         cmp("resp_err",  bus.resp_err,  e_err);
      end
   end

   // ---------------- environment ----------------
   int          mul_cnt = 0;
   int          mul_dly = 1;
   logic [PW-1:0] mul_res;
   bit          auto_req = 1'b0;
   bit          sticky   = 1'b0;
   bit          spur     = 1'b0;

   task automatic set_ch(input int ch, input int a, input int b);
      bus.req_a[ch*N +: N] = N'(a);
      bus.req_b[ch*M +: M] = M'(b);
      bus.req = bus.req | (NCH'(1) << ch);
   endtask

   // One clock: multiplier emulation, requester behaviour, random ready
   task automatic cyc();
      logic [NCH-1:0] msk;
      @(negedge clk);
      bus.mul_done = 1'b0;
      if (mul_cnt > 0) begin
         mul_cnt--;
         if (mul_cnt == 0) begin
            bus.mul_done   = 1'b1;
            bus.mul_result = mul_res;
         end
      end else if (spur && $urandom_range(0, 9) == 0) begin
         bus.mul_done   = 1'b1;
         bus.mul_result = PW'($urandom);
      end
      if (bus.mul_start && rst_n) begin
         mul_res = PW'(bus.mul_a) * PW'(bus.mul_b);
         mul_cnt = (mul_dly == 0) ? int'($urandom_range(1, 8)) : mul_dly;
         if (mul_dly < 0) mul_cnt = 0;
      end
      for (int i = 0; i < int'(NCH); i++) begin
         msk = NCH'(1) << i;
         if ((bus.gnt & msk) != 0) begin
            if (!sticky) bus.req = bus.req & ~msk;
         end else if (auto_req) begin
            if ((bus.req & msk) == 0) begin
               if ($urandom_range(0, 3) == 0) set_ch(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end else if ($urandom_range(0, 31) == 0) begin
               bus.req = bus.req & ~msk;
            end
         end
      end
      if (auto_req) bus.resp_rdy = ($urandom_range(0, 2) != 0);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      mul_cnt = 0;
      bus.mul_done = 1'b0;
      bus.req = '0;
      cyc();
      cyc();
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_vld(input int lim, output int n);
      n = 0;
      while (!bus.resp_vld && n < lim) begin
         cyc();
         n++;
      end
      cmp("resp_vld_wait", bus.resp_vld, 1'b1);
   endtask

   int n;
   int ng;
   int ci;
   int hs;
   int order [5];

   initial begin
      bus.req = '0; bus.req_a = '0; bus.req_b = '0;
      bus.mul_done = 1'b0; bus.mul_result = '0; bus.resp_rdy = 1'b1;
      cyc();
      chk_en = 1'b1;
      cyc();
      cmp("rst_gnt", bus.gnt, 0);
      cmp("rst_vld", bus.resp_vld, 0);
      cmp("rst_mul_a", bus.mul_a, 0);
      #1 rst_n = 1'b1;

      // Single request on channel 2: 7*5, product 5 cycles after launch
      mul_dly = 5;
      set_ch(2, 7, 5);
      cyc();
      cmp("s_gnt", bus.gnt, 4'b0100);
      cmp("s_start", bus.mul_start, 1);
      cmp("s_mul_a", bus.mul_a, 7);
      cmp("s_mul_b", bus.mul_b, 5);
      cyc();
      cmp("s_gnt_pulse", bus.gnt, 0);
      n = 1;
      while (!bus.resp_vld && n < 40) begin
         cyc();
         n++;
      end
      cmp("s_latency", n, 6);
      cmp("s_id", bus.resp_id, 2);
      cmp("s_data", bus.resp_data, 35);
      cmp("s_err", bus.resp_err, 0);
      cyc();
      cmp("s_vld_drop", bus.resp_vld, 0);

      // Boundary operands 15*15
      mul_dly = 3;
      set_ch(1, 15, 15);
      wait_vld(40, n);
      cmp("b_data", bus.resp_data, 8'hE1);
      cmp("b_err", bus.resp_err, 0);
      cmp("b_id", bus.resp_id, 1);
      cyc();

      // All channels requesting continuously: order 0,1,2,3,0
      do_reset();
      for (int i = 0; i < int'(NCH); i++) set_ch(i, i + 1, i + 2);
      sticky = 1'b1; mul_dly = 2; bus.resp_rdy = 1'b1;
      ng = 0; ci = 0; hs = -100;
      while (ng < 5 && ci < 200) begin
         cyc();
         ci++;
         if (bus.gnt != 0) begin
            order[ng] = idx_of(bus.gnt);
            if (ng > 0) cmp("rr_gap", ci - hs, 2);
            ng++;
         end
         if (bus.resp_vld && bus.resp_rdy) hs = ci;
      end
      cmp("rr_count", ng, 5);
      for (int k = 0; k < 5; k++) cmp("rr_order", order[k], k % 4);
      sticky = 1'b0;
      bus.req = '0;
      wait_vld(40, n);
      cyc();

      // Backpressure: 3 cycles of resp_rdy low with another channel waiting
      bus.resp_rdy = 1'b0;
      set_ch(1, 9, 6);
      wait_vld(40, n);
      cmp("bp_id0", bus.resp_id, 1);
      cmp("bp_data0", bus.resp_data, 54);
      set_ch(3, 2, 2);
      repeat (3) begin
         cyc();
         cmp("bp_vld", bus.resp_vld, 1);
         cmp("bp_id", bus.resp_id, 1);
         cmp("bp_data", bus.resp_data, 54);
         cmp("bp_gnt", bus.gnt, 0);
         cmp("bp_start", bus.mul_start, 0);
      end
      bus.resp_rdy = 1'b1;
      cyc();
      cmp("bp_release", bus.resp_vld, 0);
      cmp("bp_no_gnt", bus.gnt, 0);
      cyc();
      cmp("bp_next_gnt", bus.gnt, 4'b1000);
      wait_vld(40, n);
      cyc();

      // Reset in the middle of WAIT, then a stale mul_done
      mul_dly = -1;
      set_ch(1, 3, 4);
      n = 0;
      while (!bus.mul_start && n < 10) begin
         cyc();
         n++;
      end
      cmp("r_gnt", bus.gnt, 4'b0010);
      cyc();
      cyc();
      #1 rst_n = 1'b0;
      mul_cnt = 0;
      #1;
      cmp("r_gnt0", bus.gnt, 0);
      cmp("r_start0", bus.mul_start, 0);
      cmp("r_a0", bus.mul_a, 0);
      cmp("r_b0", bus.mul_b, 0);
      cmp("r_vld0", bus.resp_vld, 0);
      cmp("r_id0", bus.resp_id, 0);
      cmp("r_data0", bus.resp_data, 0);
      cmp("r_err0", bus.resp_err, 0);
      bus.req = '0;
      cyc();
      cyc();
      #1 rst_n = 1'b1;
      cyc();
      bus.mul_done = 1'b1;
      bus.mul_result = 8'hAA;
      repeat (3) begin
         cyc();
         cmp("r_stale_vld", bus.resp_vld, 0);
      end
      mul_dly = 2;
      for (int i = 0; i < int'(NCH); i++) set_ch(i, 2 * i + 1, 3);
      cyc();
      cmp("r_first_gnt", bus.gnt, 4'b0001);

      // Multiplier never answers
      do_reset();
      mul_dly = -1;
      set_ch(3, 5, 5);
      cyc();
      cmp("t_gnt", bus.gnt, 4'b1000);
`ifdef MULT_SCHED_TIMEOUT_EN
      n = 0;
      while (!bus.resp_vld && n < 100) begin
         cyc();
         n++;
      end
      cmp("t_latency", n, 64);
      cmp("t_err", bus.resp_err, 1);
      cmp("t_data", bus.resp_data, 0);
      cmp("t_id", bus.resp_id, 3);
      cyc();
`else
      repeat (200) begin
         cyc();
         cmp("t_no_resp", bus.resp_vld, 0);
      end
`endif

      // Randomized traffic
      do_reset();
      auto_req = 1'b1; spur = 1'b1; mul_dly = 0;
      repeat (3000) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
